// File: rtl/det_pkg.sv
// det_pkg: shared FSM state type, window-width helper and parameter legality check.
package det_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TRIP = 2'd2} state_t;
    function automatic int win_w(input int win_len);
        return $clog2(win_len + 1);
    endfunction
    function automatic bit params_ok(input int win_len, input int thresh, input int cnt_w);
        return win_len >= 2 && win_len <= 1024 && thresh >= 1 && thresh <= win_len && cnt_w >= 1;
    endfunction
endpackage

// File: rtl/det_event_monitor_if.sv
// det_event_monitor_if: control inputs and status outputs of the event monitor.
interface det_event_monitor_if #(parameter int CNT_W = 8, parameter int WIN_W = 5);
    logic en;
    logic clr;
    logic det_in;
    logic [CNT_W-1:0] total_cnt;
    logic [WIN_W-1:0] last_win_cnt;
    logic alarm_pulse;
    logic alarm_sticky;
    logic [1:0] state_o;
    modport master (output en, clr, det_in,
                    input total_cnt, last_win_cnt, alarm_pulse, alarm_sticky, state_o);
    modport slave (input en, clr, det_in,
                   output total_cnt, last_win_cnt, alarm_pulse, alarm_sticky, state_o);
endinterface

// File: rtl/det_sat_cnt.sv
// det_sat_cnt: up counter that sticks at all-ones; clr wins over inc.
module det_sat_cnt #(parameter int W = 8) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else q <= clr ? '0 : (inc && q != '1) ? q + W'(1) : q;
endmodule

// File: rtl/det_event_monitor.sv
// det_event_monitor: tumbling-window detection counter with threshold alarm and lifetime total.
module det_event_monitor
    import det_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int THRESH = 3,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    det_event_monitor_if.slave bus
);
    localparam int WIN_W = win_w(WIN_LEN);
    localparam int POS_W = $clog2(WIN_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN_LEN - 1);
    localparam logic [WIN_W-1:0] HIT_TRIP = WIN_W'(THRESH);

    generate
        if (!params_ok(WIN_LEN, THRESH, CNT_W)) begin : g_bad_params
            $error("det_event_monitor: illegal WIN_LEN/THRESH/CNT_W");
        end
    endgenerate

    state_t state, state_nxt;
    logic [POS_W-1:0] pos;
    logic [WIN_W-1:0] win_hits, hits_nxt, last_win;
    logic [CNT_W-1:0] total;
    logic pulse, sticky, pulse_nxt, sticky_nxt, trip;

    assign hits_nxt = win_hits + WIN_W'(bus.det_in);
    assign trip = state == RUN && bus.en && hits_nxt == HIT_TRIP;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    // clr shares IDLE's exit rule; encoding 3 falls through to IDLE
    always_comb
        state_nxt = (bus.clr || state == IDLE) ? (bus.en ? RUN : IDLE) :
                    state == RUN ? (!bus.en ? IDLE : trip ? TRIP : RUN) :
                    state == TRIP ? TRIP : IDLE;

    always_comb begin
        pulse_nxt = !bus.clr && trip;
        sticky_nxt = !bus.clr && (sticky || trip);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pulse <= 1'b0;
            sticky <= 1'b0;
        end else begin
            pulse <= pulse_nxt;
            sticky <= sticky_nxt;
        end

    // TRIP freezes the window; IDLE and an en drop discard it
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pos <= '0;
            win_hits <= '0;
            last_win <= '0;
        end else if (bus.clr) begin
            pos <= '0;
            win_hits <= '0;
            last_win <= '0;
        end else if (state == RUN && bus.en) begin
            if (pos == POS_LAST) begin
                last_win <= hits_nxt;
                pos <= '0;
                win_hits <= '0;
            end else begin
                pos <= pos + POS_W'(1);
                win_hits <= hits_nxt;
            end
        end else if (state != TRIP) begin
            pos <= '0;
            win_hits <= '0;
        end

    det_sat_cnt #(.W(CNT_W)) u_total (
        .clk(clk),
        .rst(rst),
        .clr(bus.clr),
        .inc(bus.det_in && (state == RUN || state == TRIP)),
        .q(total)
    );

    assign bus.total_cnt = total;
    assign bus.last_win_cnt = last_win;
    assign bus.alarm_pulse = pulse;
    assign bus.alarm_sticky = sticky;
    assign bus.state_o = state;
endmodule

// File: tb/tb_det_event_monitor.sv
// tb_det_event_monitor: directed steps with a queued per-cycle reference model, plus a 1101 detector feeding a narrow instance.
module tb_det_event_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    det_event_monitor_if #(.CNT_W(8), .WIN_W(5)) b1 ();
    det_event_monitor_if #(.CNT_W(4), .WIN_W(5)) b2 ();

    det_event_monitor #(.WIN_LEN(16), .THRESH(3), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b1));
    det_event_monitor #(.WIN_LEN(16), .THRESH(16), .CNT_W(4)) dut_sat (.clk(clk), .rst(rst), .bus(b2));

    // serial 1101 Moore detector, overlapping, registered Y
    logic s_in = 1'b0;
    logic [2:0] ds;
    logic y;
    always_ff @(posedge clk or posedge rst)
        if (rst) ds <= 3'd0;
        else case (ds)
            3'd0: ds <= s_in ? 3'd1 : 3'd0;
            3'd1: ds <= s_in ? 3'd2 : 3'd0;
            3'd2: ds <= s_in ? 3'd2 : 3'd3;
            3'd3: ds <= s_in ? 3'd4 : 3'd0;
            default: ds <= s_in ? 3'd2 : 3'd0;
        endcase
    assign y = ds == 3'd4;
    assign b2.det_in = y;

    typedef struct {int total; int last; int pulse; int sticky; int state;} exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int m_state, m_pos, m_hits, m_total, m_last, m_pulse, m_sticky;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_hits = 0; m_total = 0; m_last = 0; m_pulse = 0; m_sticky = 0;
    endtask

    task automatic model(input logic e, input logic c, input logic d);
        int h;
        m_pulse = 0;
        if (c) begin
            m_total = 0; m_last = 0; m_pos = 0; m_hits = 0; m_sticky = 0;
            m_state = e ? 1 : 0;
        end else if (m_state == 0) begin
            if (e) begin m_state = 1; m_pos = 0; m_hits = 0; end
        end else begin
            if (d) m_total = m_total < 255 ? m_total + 1 : 255;
            if (m_state == 1 && !e) begin
                m_state = 0; m_pos = 0; m_hits = 0;
            end else if (m_state == 1) begin
                h = m_hits + int'(d);
                if (h == 3) begin m_state = 2; m_pulse = 1; m_sticky = 1; end
                if (m_pos == 15) begin m_last = h; m_pos = 0; m_hits = 0; end
                else begin m_pos++; m_hits = h; end
            end
        end
    endtask

    task automatic step(input logic e, input logic c, input logic d);
        exp_t x;
        b1.en = e; b1.clr = c; b1.det_in = d;
        model(e, c, d);
        sb.push_back('{m_total, m_last, m_pulse, m_sticky, m_state});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("sb_total", 32'(b1.total_cnt), x.total);
        chk("sb_last", 32'(b1.last_win_cnt), x.last);
        chk("sb_pulse", 32'(b1.alarm_pulse), x.pulse);
        chk("sb_sticky", 32'(b1.alarm_sticky), x.sticky);
        chk("sb_state", 32'(b1.state_o), x.state);
    endtask

    task automatic window(input int a, input int b, input int c, output int np, output int at);
        np = 0; at = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, i == a || i == b || i == c);
            if (b1.alarm_pulse) begin np++; at = i; end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_total"}, 32'(b1.total_cnt), 0);
        chk({tag, "_last"}, 32'(b1.last_win_cnt), 0);
        chk({tag, "_pulse"}, 32'(b1.alarm_pulse), 0);
        chk({tag, "_sticky"}, 32'(b1.alarm_sticky), 0);
        chk({tag, "_state"}, 32'(b1.state_o), 0);
    endtask

    initial begin
        int np, at, ycnt;
        b1.en = 0; b1.clr = 0; b1.det_in = 0;
        b2.en = 0; b2.clr = 0;
        model_reset();
        #1;
        chk_zero("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        step(0, 0, 0);
        // reset mid-window after two detections
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, i == 1 || i == 4);
        chk("pre_rst_total", 32'(b1.total_cnt), 2);
        #2 rst = 1;
        #1 chk_zero("rst");
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        // two detections, window starts fresh at pos 0
        step(1, 0, 0);
        window(3, 10, -1, np, at);
        chk("two_pulses", np, 0);
        chk("two_last", 32'(b1.last_win_cnt), 2);
        chk("two_total", 32'(b1.total_cnt), 2);
        chk("two_state", 32'(b1.state_o), 1);
        // threshold trip at cycle 9
        window(2, 5, 9, np, at);
        chk("trip_pulses", np, 1);
        chk("trip_at", at, 9);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 1);
        chk("trip_total", 32'(b1.total_cnt), 7);
        chk("trip_state", 32'(b1.state_o), 2);
        chk("trip_sticky", 32'(b1.alarm_sticky), 1);
        chk("trip_last", 32'(b1.last_win_cnt), 2);
        // clr beats coincident det_in and en
        step(1, 1, 1);
        chk("clr_total", 32'(b1.total_cnt), 0);
        chk("clr_sticky", 32'(b1.alarm_sticky), 0);
        chk("clr_state", 32'(b1.state_o), 1);
        // trip and window end on the same edge
        window(4, 8, 15, np, at);
        chk("edge_at", at, 15);
        chk("edge_last", 32'(b1.last_win_cnt), 3);
        chk("edge_state", 32'(b1.state_o), 2);
        chk("edge_total", 32'(b1.total_cnt), 3);
        step(0, 1, 0);
        chk("clr_idle_state", 32'(b1.state_o), 0);
        // en drop discards the partial window but counts the coincident detection
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("drop_total", 32'(b1.total_cnt), 2);
        chk("drop_last", 32'(b1.last_win_cnt), 0);
        chk("drop_state", 32'(b1.state_o), 0);
        step(0, 0, 0);
        // 1101 x20 through the detector into the 4-bit instance
        b2.en = 1;
        @(posedge clk); #1;
        ycnt = 0;
        for (int i = 0; i < 84; i++) begin
            s_in = i < 80 && (i % 4) != 2;
            @(posedge clk); #1;
            ycnt += int'(y);
        end
        chk("sat_ypulses", ycnt, 20);
        chk("sat_total", 32'(b2.total_cnt), 15);
        chk("sat_state", 32'(b2.state_o), 1);
        chk("sat_sticky", 32'(b2.alarm_sticky), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
